// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Sequencer for the streaming-convolution sample buffer. Writes each accepted input sample
//   into a circular buffer and, once a full kernel of samples is present, presents one window
//   per stride as a set of read addresses ordered oldest-first.
//
// Ports
//   clk_i             rising-edge clock
//   rst_i             synchronous, active-high reset
//   start_i           launches a frame (ignored while busy)
//   cfg_frame_len_i   samples per frame, latched on start
//   cfg_stride_i      window stride, latched on start (0 behaves as 1)
//   busy_o            frame in progress
//   done_o            single-cycle pulse at frame completion
//   in_valid_i/in_ready_o/in_data_i      input sample stream
//   mem_en_o/mem_addr_o/mem_data_o       buffer write port (combinational)
//   mem_read_addr_o   K read addresses, index 0 = oldest sample of the window
//   win_valid_o/win_ready_i              window handshake
//   win_idx_o         window index within the frame
module conv_window_ctrl #(
   parameter int unsigned MEMORY_SIZE   = 24,
   parameter int unsigned READ_ADDR_LEN = 8,
   parameter int unsigned INPUT_PREC    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [15:0]           cfg_frame_len_i,
   input  logic [3:0]            cfg_stride_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [INPUT_PREC-1:0] in_data_i,
   output logic                  mem_en_o,
   output logic [INPUT_PREC-1:0] mem_addr_o,
   output logic [INPUT_PREC-1:0] mem_data_o,
   output logic [INPUT_PREC-1:0] mem_read_addr_o [READ_ADDR_LEN],
   output logic                  win_valid_o,
   input  logic                  win_ready_i,
   output logic [15:0]           win_idx_o
);

   localparam int unsigned AW = INPUT_PREC;
   // One extra bit so MEMORY_SIZE itself (up to 2**AW) and base+i sums are representable.
   localparam int unsigned SW = INPUT_PREC + 1;
   localparam logic [SW-1:0] MemSize  = SW'(MEMORY_SIZE);
   localparam logic [SW-1:0] KMinus1  = SW'(READ_ADDR_LEN - 1);
   localparam logic [AW-1:0] LastAddr = AW'(MEMORY_SIZE - 1);
   localparam logic [15:0]   PhaseInit = 16'(READ_ADDR_LEN - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e          state_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [15:0]     n_q;
   logic [15:0]     phase_q;      // accepts remaining until the next producing sample
   logic [15:0]     stride_m1_q;
   logic [15:0]     frame_len_q;
   logic [15:0]     win_idx_q;
   logic            win_valid_q;
   logic [AW-1:0]   rd_addr_q [READ_ADDR_LEN];
   logic [AW-1:0]   rd_addr_d [READ_ADDR_LEN];

   logic            in_ready;
   logic            accept;
   logic            produce;
   logic            last;
   logic            hs;
   logic [SW-1:0]   base;
   logic [SW-1:0]   sum;

   assign in_ready = (state_q == StRun) && !(win_valid_q && !win_ready_i);
   assign accept   = in_valid_i && in_ready;
   assign produce  = accept && (phase_q == 16'd0);
   assign last     = accept && ((n_q + 16'd1) == frame_len_q);
   assign hs       = win_valid_q && win_ready_i;

   // Window addresses derived from the slot being written this cycle (the newest sample).
   always_comb begin
      sum = '0;
      if ({1'b0, wr_ptr_q} >= KMinus1) begin
         base = {1'b0, wr_ptr_q} - KMinus1;
      end else begin
         base = {1'b0, wr_ptr_q} + MemSize - KMinus1;
      end
      for (int i = 0; i < READ_ADDR_LEN; i++) begin
         sum = base + SW'(i);
         if (sum >= MemSize) begin
            sum = sum - MemSize;
         end
         rd_addr_d[i] = sum[AW-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         n_q         <= '0;
         phase_q     <= '0;
         stride_m1_q <= '0;
         frame_len_q <= '0;
         win_idx_q   <= '0;
         win_valid_q <= 1'b0;
         for (int i = 0; i < READ_ADDR_LEN; i++) begin
            rd_addr_q[i] <= '0;
         end
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  frame_len_q <= cfg_frame_len_i;
                  stride_m1_q <= (cfg_stride_i == 4'd0) ? 16'd0 : {12'd0, cfg_stride_i - 4'd1};
                  n_q         <= '0;
                  phase_q     <= PhaseInit;
                  win_idx_q   <= '0;
                  state_q     <= (cfg_frame_len_i == 16'd0) ? StDone : StRun;
               end
            end
            StRun: begin
               if (accept) begin
                  wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
                  n_q      <= n_q + 16'd1;
                  phase_q  <= produce ? stride_m1_q : phase_q - 16'd1;
                  if (last) begin
                     state_q <= produce ? StDrain : StDone;
                  end
               end
            end
            StDrain: begin
               if (hs) begin
                  state_q <= StDone;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase

         if (hs) begin
            win_idx_q   <= win_idx_q + 16'd1;
            win_valid_q <= 1'b0;
         end
         // A new window overrides the clear when consume and produce coincide.
         if (produce) begin
            win_valid_q <= 1'b1;
            rd_addr_q   <= rd_addr_d;
         end
      end
   end

   assign busy_o          = (state_q == StRun) || (state_q == StDrain);
   assign done_o          = (state_q == StDone);
   assign in_ready_o      = in_ready;
   assign mem_en_o        = accept;
   assign mem_addr_o      = wr_ptr_q;
   assign mem_data_o      = in_data_i;
   assign mem_read_addr_o = rd_addr_q;
   assign win_valid_o     = win_valid_q;
   assign win_idx_o       = win_idx_q;

endmodule
